// File: rtl/dmem_line_responder_pkg.sv
// Shared types and helpers for the data-memory line responder.
// Line geometry, FSM state encoding and byte-address to line-index mapping.
package dmem_line_responder_pkg;

   localparam int LINE_BITS   = 256;
   localparam int ADDR_BITS   = 32;
   localparam int OFFSET_BITS = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      ACK  = 2'd2
   } state_t;

   // Drops the byte offset and keeps only the low idx_bits of the line number,
   // so addresses wrap modulo the number of lines.
   function automatic int unsigned line_idx(input logic [ADDR_BITS-1:0] addr,
                                            input int unsigned idx_bits);
      logic [ADDR_BITS-1:0] mask;
      mask = (ADDR_BITS'(1) << idx_bits) - ADDR_BITS'(1);
      return int'((addr >> OFFSET_BITS) & mask);
   endfunction

endpackage

// File: rtl/dmem_line_responder.sv
// Line-granular memory responder for the data cache; ack pulses LATENCY cycles after a request is accepted.
// One request in flight: enable_i is only sampled in IDLE, so the initiator holds it until it sees ack.
module dmem_line_responder #(
   parameter int LINE_BITS = dmem_line_responder_pkg::LINE_BITS,
   parameter int ADDR_BITS = dmem_line_responder_pkg::ADDR_BITS,
   parameter int DEPTH     = 512,
   parameter int LATENCY   = 10
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [ADDR_BITS-1:0] addr_i,
   input  logic [LINE_BITS-1:0] data_i,
   input  logic                 enable_i,
   input  logic                 write_i,
   output logic                 ack_o,
   output logic [LINE_BITS-1:0] data_o,
   output logic                 busy_o
);
   import dmem_line_responder_pkg::*;

   localparam int IDX_BITS = $clog2(DEPTH);
   localparam int CNT_W    = $clog2(LATENCY + 1);

   logic [LINE_BITS-1:0] mem [DEPTH];

   state_t               state;
   state_t               state_nxt;
   logic [CNT_W-1:0]     cnt;
   logic [IDX_BITS-1:0]  idx_q;
   logic                 wr_q;
   logic [LINE_BITS-1:0] wdat_q;

   logic [IDX_BITS-1:0]  idx_in;
   logic                 cnt_last;
   logic                 acc_en;
   logic [IDX_BITS-1:0]  acc_idx;
   logic                 acc_wr;
   logic [LINE_BITS-1:0] acc_dat;

   assign idx_in   = IDX_BITS'(line_idx(addr_i, IDX_BITS));
   assign cnt_last = (cnt == CNT_W'(LATENCY - 1));

   // With LATENCY==1 the access happens on the accepting edge, before anything is latched.
   assign acc_idx  = (state == IDLE) ? idx_in   : idx_q;
   assign acc_wr   = (state == IDLE) ? write_i  : wr_q;
   assign acc_dat  = (state == IDLE) ? data_i   : wdat_q;

   always_comb begin
      state_nxt = state;
      acc_en    = 1'b0;
      case (state)
         IDLE: begin
            if (enable_i) begin
               state_nxt = (LATENCY == 1) ? ACK : WAIT;
               acc_en    = (LATENCY == 1);
            end
         end
         WAIT: begin
            if (cnt_last) begin
               state_nxt = ACK;
               acc_en    = 1'b1;
            end
         end
         ACK:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign ack_o  = (state == ACK);
   assign busy_o = (state != IDLE);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state  <= IDLE;
         cnt    <= '0;
         data_o <= '0;
         idx_q  <= '0;
         wr_q   <= 1'b0;
         wdat_q <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && enable_i) begin
            idx_q  <= idx_in;
            wr_q   <= write_i;
            wdat_q <= data_i;
            cnt    <= CNT_W'(1);
         end else if (state == WAIT && !cnt_last) begin
            cnt <= cnt + CNT_W'(1);
         end
         if (acc_en && !acc_wr) begin
            data_o <= mem[acc_idx];
         end
      end
   end

   // Storage is deliberately not reset; a reset on the access edge drops the write.
   always_ff @(posedge clk_i) begin
      if (!rst_i && acc_en && acc_wr) begin
         mem[acc_idx] <= acc_dat;
      end
   end

endmodule
